// File: rtl/bram_fifo_pkg.sv
// ============================================================================
// Module   : bram_fifo_pkg
// Purpose  : Shared default geometry for the block-RAM FIFO and its RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_fifo_pkg;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 4;
endpackage

`default_nettype wire

// File: rtl/bram_fifo_dp_bram.sv
// ============================================================================
// Module   : dp_bram
// Purpose  : Simple dual-port RAM, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_bram
    import bram_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // No reset on the array or read register so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_fifo.sv
// ============================================================================
// Module   : bram_fifo
// Purpose  : Parametrised synchronous FIFO with occupancy, flags and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int AF_LEVEL = (2**ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              full,
    output logic              almost_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_COUNT = (ADDR_W+1)'(AF_LEVEL);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            wr_accept;
    logic            rd_accept;

    // Flags come only from the registered pointers; the extra MSB tells full from empty.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AF_COUNT);

    assign wr_accept = w_en && !full && !rst;
    assign rd_accept = r_en && !empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            r_valid   <= rd_accept;
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end

    dp_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .w_en   (wr_accept),
        .w_addr (wr_ptr[ADDR_W-1:0]),
        .w_data (w_data),
        .r_en   (rd_accept),
        .r_addr (rd_ptr[ADDR_W-1:0]),
        .r_data (r_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_fifo.sv
// ============================================================================
// Module   : tb_bram_fifo
// Purpose  : Self-checking bench for bram_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       full, almost_full, r_valid, empty, overflow, underflow;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_rv, m_ov, m_uf;
    logic [7:0] m_data;

    typedef struct {
        bit         rs;
        bit         w;
        logic [7:0] d;
        bit         r;
        int         cnt;
        bit         rv;
        logic [7:0] rd;
        bit         emp;
        bit         ov;
        bit         uf;
    } vec_t;

    vec_t tbl[10];

    bram_fifo #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .w_data      (w_data),
        .full        (full),
        .almost_full (almost_full),
        .r_en        (r_en),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the FIFO model by its rules, compare every output.
    task automatic apply(input bit rs, input bit w, input logic [7:0] d, input bit r);
        int sz;
        rst = rs; w_en = w; w_data = d; r_en = r;
        @(posedge clk);
        #1;
        sz = q.size();
        if (rs) begin
            q.delete();
            m_rv = 0; m_ov = 0; m_uf = 0;
        end else begin
            m_ov = w && (sz == DEPTH);
            m_uf = r && (sz == 0);
            m_rv = r && (sz > 0);
            if (m_rv) m_data = q.pop_front();
            if (w && sz < DEPTH) q.push_back(d);
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        chk("r_valid", 32'(r_valid), 32'(m_rv));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_uf));
        if (m_rv) chk("r_data", 32'(r_data), 32'(m_data));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 8'h00, 0);
    endtask

    initial begin
        tbl[0] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0};
        tbl[1] = '{0, 1, 8'hA5, 0, 1, 0, 8'h00, 0, 0, 0};
        tbl[2] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0};
        tbl[3] = '{0, 0, 8'h00, 1, 0, 1, 8'hA5, 1, 0, 0};
        tbl[4] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0};
        tbl[5] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1};
        tbl[6] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0};
        tbl[7] = '{0, 1, 8'h3C, 1, 1, 0, 8'h00, 0, 0, 1};
        tbl[8] = '{0, 0, 8'h00, 1, 0, 1, 8'h3C, 1, 0, 0};
        tbl[9] = '{1, 1, 8'h77, 0, 0, 0, 8'h00, 1, 0, 0};

        apply(1, 0, 8'h00, 0);
        apply(1, 0, 8'h00, 0);
        idle(5);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].rs, tbl[i].w, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_rvalid", i), 32'(r_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].uf));
            if (tbl[i].rv) chk($sformatf("tbl%0d_rdata", i), 32'(r_data), 32'(tbl[i].rd));
        end

        // Fill to capacity, one dropped write, then drain in order.
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 8'(i), 0);
            if (i == 12) chk("af_below", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at_level", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        apply(0, 1, 8'hFF, 0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        apply(0, 0, 8'h00, 1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) apply(0, 0, 8'h00, 1);
        idle(1);
        chk("drain_empty", 32'(empty), 32'd1);

        // Pointer wrap past the RAM depth.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) apply(0, 1, 8'($urandom), 0);
            for (int i = 0; i < 10; i++) apply(0, 0, 8'h00, 1);
            idle(1);
        end
        for (int i = 8'h11; i <= 8'h1F; i++) apply(0, 1, 8'(i), 0);
        for (int i = 0; i < 15; i++) apply(0, 0, 8'h00, 1);
        idle(1);

        // Steady occupancy of 8 under simultaneous push and pop.
        for (int i = 0; i < 8; i++) apply(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 20; i++) begin
            apply(0, 1, 8'($urandom), 1);
            chk("steady_count", 32'(count), 32'd8);
            chk("steady_rvalid", 32'(r_valid), 32'd1);
        end
        for (int i = 0; i < 8; i++) apply(0, 0, 8'h00, 1);
        idle(1);

        // Full with both requests: only the read proceeds.
        for (int i = 0; i < 16; i++) apply(0, 1, 8'($urandom), 0);
        apply(0, 1, 8'hEE, 1);
        chk("full_both_ovf", 32'(overflow), 32'd1);
        chk("full_both_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) apply(0, 0, 8'h00, 1);
        idle(1);

        // Reset while a read is requested.
        apply(0, 1, 8'h5A, 0);
        apply(0, 1, 8'h6B, 0);
        apply(0, 0, 8'h00, 1);
        apply(1, 0, 8'h00, 1);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        idle(2);

        // Randomised traffic with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 70 : 30;
            apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < wp),
                  8'($urandom), ($urandom_range(0, 99) < (100 - wp)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
